// File: rtl/pattern_detector_param_if.sv
// Bus bundle for pattern_detector_param: raw step/data/mode/pattern in, match flag,
// history fill count and match counter out.
interface pattern_detector_param_if #(
    parameter int N    = 6,
    parameter int CNTW = 8
);
    localparam int PW = $clog2(N + 1);

    logic            step;
    logic            x;
    logic            m;
    logic [N-1:0]    pattern;
    logic            z;
    logic [PW-1:0]   q;
    logic [CNTW-1:0] match_cnt;

    modport master (
        output step, x, m, pattern,
        input  z, q, match_cnt
    );

    modport slave (
        input  step, x, m, pattern,
        output z, q, match_cnt
    );
endinterface

// File: rtl/pattern_detector_param.sv
// Debounced-step serial pattern detector with overlapping/non-overlapping modes.
// Optional saturating match counter enabled by macro SEQDET_MATCH_COUNT_EN.
module pattern_detector_param #(
    parameter int N    = 6,
    parameter int DBW  = 4,
    parameter int CNTW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pattern_detector_param_if.slave bus
);
    localparam int PW = $clog2(N + 1);
    localparam logic [PW-1:0] QFULL = PW'(N);

    // DB_UNARMED holds the stable level low until the input has been seen low for a
    // full debounce window, so a step held through reset never produces a step.
    typedef enum logic [1:0] {
        DB_UNARMED,
        DB_LOW,
        DB_HIGH
    } db_state_t;

    db_state_t      db_state;
    db_state_t      db_next;
    logic [1:0]     sync;
    logic [DBW-1:0] db_cnt;
    logic [DBW-1:0] db_cnt_next;
    logic           db_target;
    logic           step_en;

    logic [N-1:0]   hist;
    logic [N-1:0]   hist_shift;
    logic [PW-1:0]  count;
    logic [PW-1:0]  count_inc;
    logic           match;
    logic           match_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], bus.step};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_state <= DB_UNARMED;
            db_cnt   <= '0;
        end else begin
            db_state <= db_next;
            db_cnt   <= db_cnt_next;
        end
    end

    always_comb begin
        db_next     = db_state;
        db_cnt_next = '0;
        step_en     = 1'b0;
        db_target   = (db_state == DB_LOW);
        if (sync[1] == db_target) begin
            if (db_cnt == '1) begin
                case (db_state)
                    DB_UNARMED: db_next = DB_LOW;
                    DB_LOW: begin
                        db_next = DB_HIGH;
                        step_en = 1'b1;
                    end
                    DB_HIGH:    db_next = DB_LOW;
                    default:    db_next = DB_UNARMED;
                endcase
            end else begin
                db_cnt_next = db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        hist_shift = {hist[N-2:0], bus.x};
        count_inc  = (count == QFULL) ? QFULL : count + 1'b1;
        match      = (hist_shift == bus.pattern) && (count_inc == QFULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist       <= '0;
            count      <= '0;
            match_flag <= 1'b0;
        end else if (step_en) begin
            hist       <= hist_shift;
            match_flag <= match;
            count      <= (match && !bus.m) ? '0 : count_inc;
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNTW-1:0] match_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (step_en && match && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

    assign bus.match_cnt = match_count;
`else
    assign bus.match_cnt = '0;
`endif

    assign bus.z = match_flag;
    assign bus.q = count;
endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed, table-driven bench for pattern_detector_param (N=6, DBW=4, CNTW=8).
module tb_pattern_detector_param;
    logic clk;
    logic reset;

    pattern_detector_param_if #(.N(6), .CNTW(8)) bus ();

    pattern_detector_param #(
        .N   (6),
        .DBW (4),
        .CNTW(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic       x;
        logic       m;
        logic [5:0] pattern;
        logic       z;
        logic [2:0] q;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[24];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic xb, input logic mb,
                                input logic [5:0] p, input logic zb,
                                input int qv, input int cv);
        vec_t v;
        v.rst_first = r;
        v.x         = xb;
        v.m         = mb;
        v.pattern   = p;
        v.z         = zb;
        v.q         = 3'(qv);
        v.cnt       = 8'(cv);
        return v;
    endfunction

    function automatic logic [7:0] exp_cnt(input logic [7:0] v);
`ifdef SEQDET_MATCH_COUNT_EN
        return v;
`else
        return (v == v) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic zb, input int qv, input logic [7:0] cv);
        check({name, ".z"}, 32'(bus.z), 32'(zb));
        check({name, ".q"}, 32'(bus.q), 32'(qv));
        check({name, ".cnt"}, 32'(bus.match_cnt), 32'(exp_cnt(cv)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (22) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.x    = b;
        bus.step = 1'b1;
        repeat (22) @(negedge clk);
        bus.step = 1'b0;
        repeat (22) @(negedge clk);
    endtask

    initial begin
        logic [8:0] s29;

        // Clean 6-bit match, then overlapping and non-overlapping runs of 101101 stream.
        vecs[0] = mk(1, 0, 1, 6'b010110, 0, 1, 0);
        vecs[1] = mk(0, 1, 1, 6'b010110, 0, 2, 0);
        vecs[2] = mk(0, 0, 1, 6'b010110, 0, 3, 0);
        vecs[3] = mk(0, 1, 1, 6'b010110, 0, 4, 0);
        vecs[4] = mk(0, 1, 1, 6'b010110, 0, 5, 0);
        vecs[5] = mk(0, 0, 1, 6'b010110, 1, 6, 1);
        s29 = 9'b101101101;
        for (int i = 0; i < 9; i++) begin
            vecs[6 + i]  = mk(i == 0, s29[8 - i], 1, 6'b101101,
                              (i == 5) || (i == 8), (i < 6) ? i + 1 : 6,
                              (i < 5) ? 0 : ((i < 8) ? 1 : 2));
            vecs[15 + i] = mk(i == 0, s29[8 - i], 0, 6'b101101,
                              (i == 5), (i < 5) ? i + 1 : ((i == 5) ? 0 : i - 5),
                              (i < 5) ? 0 : 1);
        end

        reset       = 1'b1;
        bus.step    = 1'b0;
        bus.x       = 1'b0;
        bus.m       = 1'b1;
        bus.pattern = 6'b010110;
        #1;
        check_outs("reset_state", 1'b0, 0, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (22) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].rst_first) do_reset();
            bus.m       = vecs[i].m;
            bus.pattern = vecs[i].pattern;
            send_bit(vecs[i].x);
            check_outs($sformatf("vec%0d", i), vecs[i].z, int'(vecs[i].q), vecs[i].cnt);
        end

        // Bounce: 5-cycle high pulses never survive the debounce window.
        do_reset();
        bus.x = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.step = 1'b1;
            repeat (5) @(negedge clk);
            bus.step = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("bounce_none", 32'(bus.q), 32'd0);
        bus.step = 1'b1;
        repeat (20) @(negedge clk);
        check("bounce_one", 32'(bus.q), 32'd1);
        bus.step = 1'b0;
        repeat (22) @(negedge clk);
        check("bounce_release", 32'(bus.q), 32'd1);

        // Step held through reset must not register until released and pressed again.
        bus.step = 1'b1;
        do_reset();
        repeat (30) @(negedge clk);
        check("held_through_reset", 32'(bus.q), 32'd0);
        bus.step = 1'b0;
        repeat (22) @(negedge clk);
        send_bit(1'b1);
        check("repress_after_reset", 32'(bus.q), 32'd1);

        // Reset mid-sequence, then a fresh full pattern.
        do_reset();
        bus.m       = 1'b1;
        bus.pattern = 6'b010110;
        for (int i = 0; i < 4; i++) send_bit(bus.pattern[5 - i]);
        check("mid_q_before", 32'(bus.q), 32'd4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("mid_reset", 1'b0, 0, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (22) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            send_bit(bus.pattern[5 - i]);
            check_outs($sformatf("mid_step%0d", i + 1), i == 5, i + 1, (i == 5) ? 8'd1 : 8'd0);
        end

        // Counter saturation: all-zero pattern matches on every step once full.
        do_reset();
        bus.m       = 1'b1;
        bus.pattern = 6'b000000;
        for (int k = 1; k <= 260; k++) send_bit(1'b0);
        check_outs("sat_255", 1'b1, 6, 8'd255);
        send_bit(1'b0);
        check_outs("sat_hold", 1'b1, 6, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
